chimera_cluster_ctrl: RTL and testbench

CHIMERA_CLUSTER_CTRL -- requirements
Module: chimera_cluster_ctrl

---
 rtl/chimera_cluster_ctrl.sv | 153 +++++++++++++++
 tb/tb_chimera_cluster_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chimera_cluster_ctrl.sv
// Register-mapped power sequencer for external clusters: each cluster ramps
// clock-enable then reset release, and the reverse, with a fixed settle gap.
module chimera_cluster_ctrl #(
  parameter int unsigned NumClusters  = 5,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned SettleCycles = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   reg_valid_i,
  input  logic                   reg_write_i,
  input  logic [AddrWidth-1:0]   reg_addr_i,
  input  logic [DataWidth-1:0]   reg_wdata_i,
  input  logic [DataWidth/8-1:0] reg_wstrb_i,
  output logic                   reg_ready_o,
  output logic [DataWidth-1:0]   reg_rdata_o,
  output logic                   reg_error_o,
  output logic [NumClusters-1:0] cluster_clk_en_o,
  output logic [NumClusters-1:0] cluster_rst_no
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned CntWidth  = (SettleCycles == 0) ? 1 : $clog2(SettleCycles + 1);
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(SettleCycles);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StClkOn = 2'd1,
    StRun   = 2'd2,
    StRstOn = 2'd3
  } state_e;

  state_e                 state_q [NumClusters];
  logic [CntWidth-1:0]    cnt_q   [NumClusters];
  logic [NumClusters-1:0] clk_en_q, rst_n_q;
  logic [NumClusters-1:0] en_q;
  logic [DataWidth-1:0]   scratch_q;
  logic                   ready_q, error_q;
  logic [DataWidth-1:0]   rdata_q;

  logic [11:0]            offset_c;
  logic                   sample_c, err_c;
  logic [DataWidth-1:0]   wmask_c, rdata_c, en_merged_c;
  logic [NumClusters-1:0] status_c, busy_c;
  logic                   unused_addr_c;

  assign offset_c      = reg_addr_i[11:0];
  assign unused_addr_c = ^reg_addr_i[AddrWidth-1:12];
  assign sample_c      = reg_valid_i & ~ready_q;
  assign err_c         = (|offset_c[11:4]) | (|offset_c[1:0]);

  // Byte-strobe expansion, per-cluster status, and read mux (values before the edge)
  always_comb begin
    wmask_c = '0;
    for (int unsigned b = 0; b < StrbWidth; b++) begin
      wmask_c[8*b +: 8] = {8{reg_wstrb_i[b]}};
    end
    status_c = '0;
    busy_c   = '0;
    for (int unsigned i = 0; i < NumClusters; i++) begin
      status_c[i] = (state_q[i] == StRun);
      busy_c[i]   = (state_q[i] == StClkOn) || (state_q[i] == StRstOn);
    end
    en_merged_c = (DataWidth'(en_q) & ~wmask_c) | (reg_wdata_i & wmask_c);
    rdata_c = '0;
    case (offset_c[3:2])
      2'd0:    rdata_c = DataWidth'(en_q);
      2'd1:    rdata_c = DataWidth'(status_c);
      2'd2:    rdata_c = DataWidth'(busy_c);
      default: rdata_c = scratch_q;
    endcase
  end

  // Register bus: sample once, respond the next cycle, ignore the ready cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      en_q      <= '0;
      scratch_q <= '0;
    end else begin
      ready_q <= sample_c;
      error_q <= sample_c & err_c;
      rdata_q <= (sample_c && !err_c) ? rdata_c : '0;
      if (sample_c && reg_write_i && !err_c) begin
        case (offset_c[3:2])
          2'd0:    en_q      <= NumClusters'(en_merged_c);
          2'd3:    scratch_q <= (scratch_q & ~wmask_c) | (reg_wdata_i & wmask_c);
          default: ;
        endcase
      end
    end
  end

  // Per-cluster sequencers; a started ramp always completes before re-reading the enable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_en_q <= '0;
      rst_n_q  <= '0;
      for (int unsigned i = 0; i < NumClusters; i++) begin
        state_q[i] <= StOff;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumClusters; i++) begin
        case (state_q[i])
          StOff: begin
            if (en_q[i]) begin
              state_q[i]  <= StClkOn;
              cnt_q[i]    <= CntLoad;
              clk_en_q[i] <= 1'b1;
            end
          end
          StClkOn: begin
            if (cnt_q[i] <= CntOne) begin
              state_q[i] <= StRun;
              cnt_q[i]   <= '0;
              rst_n_q[i] <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] - CntOne;
            end
          end
          StRun: begin
            if (!en_q[i]) begin
              state_q[i] <= StRstOn;
              cnt_q[i]   <= CntLoad;
              rst_n_q[i] <= 1'b0;
            end
          end
          default: begin
            if (cnt_q[i] <= CntOne) begin
              state_q[i]  <= StOff;
              cnt_q[i]    <= '0;
              clk_en_q[i] <= 1'b0;
            end else begin
              cnt_q[i] <= cnt_q[i] - CntOne;
            end
          end
        endcase
      end
    end
  end

  assign reg_ready_o      = ready_q;
  assign reg_rdata_o      = rdata_q;
  assign reg_error_o      = error_q;
  assign cluster_clk_en_o = clk_en_q;
  assign cluster_rst_no   = rst_n_q;

endmodule

// File: tb/tb_chimera_cluster_ctrl.sv
// Randomised bench for chimera_cluster_ctrl: a cycle-level reference model
// predicts responses and cluster pins; a monitor compares them against the DUT.
module tb_chimera_cluster_ctrl;

  localparam int unsigned NC = 5;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned S  = 4;

  logic          clk, rst_n;
  logic          reg_valid, reg_write;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [SW-1:0] reg_wstrb;
  logic          reg_ready, reg_error;
  logic [DW-1:0] reg_rdata;
  logic [NC-1:0] clk_en, rst_n_o;

  chimera_cluster_ctrl #(
    .NumClusters(NC), .AddrWidth(AW), .DataWidth(DW), .SettleCycles(S)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .reg_valid_i(reg_valid), .reg_write_i(reg_write), .reg_addr_i(reg_addr),
    .reg_wdata_i(reg_wdata), .reg_wstrb_i(reg_wstrb),
    .reg_ready_o(reg_ready), .reg_rdata_o(reg_rdata), .reg_error_o(reg_error),
    .cluster_clk_en_o(clk_en), .cluster_rst_no(rst_n_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } resp_t;

  resp_t         exp_q[$];
  int            errors = 0;
  int            checks = 0;

  // Model: each cluster holds its pin levels, a ramp direction and the
  // number of edges left until the next pin toggles.
  bit [NC-1:0]   m_en;
  bit [DW-1:0]   m_scratch;
  bit            m_ck[NC], m_rs[NC], m_up[NC];
  int            m_left[NC];
  bit            m_ready;
  bit [NC-1:0]   exp_ck, exp_rs;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = '0; m_scratch = '0; m_ready = 1'b0;
    exp_ck = '0; exp_rs = '0;
    for (int i = 0; i < NC; i++) begin
      m_ck[i] = 1'b0; m_rs[i] = 1'b0; m_up[i] = 1'b0; m_left[i] = 0;
    end
    exp_q.delete();
  endtask

  // Predict the effect of the coming rising edge from the current inputs.
  task automatic model_edge(output bit sampled);
    bit [NC-1:0]   st, bz;
    logic [11:0]   off;
    logic [DW-1:0] mask, rd;
    bit            err;
    resp_t         r;
    sampled = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NC; i++) begin
      st[i] = m_ck[i] && m_rs[i];
      bz[i] = m_ck[i] && !m_rs[i];
    end
    sampled = reg_valid && !m_ready;
    for (int i = 0; i < NC; i++) begin
      if (!m_ck[i]) begin
        if (m_en[i]) begin
          m_ck[i] = 1'b1; m_up[i] = 1'b1; m_left[i] = (S == 0) ? 1 : S;
        end
      end else if (!m_rs[i]) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          if (m_up[i]) m_rs[i] = 1'b1;
          else         m_ck[i] = 1'b0;
        end
      end else if (!m_en[i]) begin
        m_rs[i] = 1'b0; m_up[i] = 1'b0; m_left[i] = (S == 0) ? 1 : S;
      end
    end
    m_ready = sampled;
    if (sampled) begin
      off = reg_addr[11:0];
      err = (off > 12'h00C) || (off[1:0] != 2'b00);
      case (off)
        12'h000: rd = DW'(m_en);
        12'h004: rd = DW'(st);
        12'h008: rd = DW'(bz);
        default: rd = m_scratch;
      endcase
      r.rdata = err ? '0 : rd;
      r.err   = err;
      exp_q.push_back(r);
      for (int b = 0; b < SW; b++) mask[8*b +: 8] = {8{reg_wstrb[b]}};
      if (reg_write && !err) begin
        if (off == 12'h000) m_en = NC'((DW'(m_en) & ~mask) | (reg_wdata & mask));
        if (off == 12'h00C) m_scratch = (m_scratch & ~mask) | (reg_wdata & mask);
      end
    end
    for (int i = 0; i < NC; i++) begin
      exp_ck[i] = m_ck[i];
      exp_rs[i] = m_rs[i];
    end
  endtask

  task automatic step(output bit sampled);
    model_edge(sampled);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit s;
    for (int k = 0; k < n; k++) step(s);
  endtask

  // Drive one access and hold it until its response cycle is on the bus.
  task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] strb);
    bit s;
    int tries;
    reg_valid = 1'b1; reg_write = wr; reg_addr = a; reg_wdata = d; reg_wstrb = strb;
    s = 1'b0;
    tries = 0;
    while (!s && tries < 4) begin
      step(s);
      tries++;
    end
    checks++;
    if (!s) begin
      errors++;
      $display("FAIL req_accept: got no acceptance, expected one within 4 cycles");
    end
    reg_valid = 1'b0;
  endtask

  // Monitor: compare pins and responses just after each rising edge.
  always @(posedge clk) begin
    resp_t r;
    #1;
    chk("clk_en", DW'(clk_en), DW'(exp_ck));
    chk("rst_n", DW'(rst_n_o), DW'(exp_rs));
    chk("ready", DW'(reg_ready), DW'(m_ready));
    if (reg_ready) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_resp: got ready=1, expected no response");
      end else begin
        r = exp_q.pop_front();
        chk("rdata", reg_rdata, r.rdata);
        chk("error", DW'(reg_error), DW'(r.err));
      end
    end else begin
      chk("idle_rdata", reg_rdata, '0);
      chk("idle_error", DW'(reg_error), '0);
    end
  end

  function automatic logic [AW-1:0] rand_addr();
    logic [11:0] off;
    case ($urandom_range(0, 7))
      0: off = 12'h000;
      1: off = 12'h004;
      2: off = 12'h008;
      3: off = 12'h00C;
      4: off = 12'h010;
      5: off = 12'h002;
      6: off = 12'hFFC;
      default: off = 12'($urandom);
    endcase
    return {20'($urandom), off};
  endfunction

  task automatic chk_all_zero(input string name);
    chk({name, "_clk_en"}, DW'(clk_en), '0);
    chk({name, "_rst_n"}, DW'(rst_n_o), '0);
    chk({name, "_ready"}, DW'(reg_ready), '0);
    chk({name, "_rdata"}, reg_rdata, '0);
    chk({name, "_error"}, DW'(reg_error), '0);
  endtask

  initial begin
    bit s;
    rst_n = 1'b0; reg_valid = 1'b0; reg_write = 1'b0;
    reg_addr = '0; reg_wdata = '0; reg_wstrb = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Power up cluster 0, then observe status and power it down
    do_req(1'b1, 32'h0000_0000, 32'h1, 4'hF);
    idle(2);
    do_req(1'b0, 32'h0000_0008, '0, 4'h0);
    idle(6);
    do_req(1'b0, 32'h0000_0004, '0, 4'h0);
    do_req(1'b1, 32'h0000_0000, 32'h0, 4'hF);
    idle(8);
    do_req(1'b0, 32'h0000_0004, '0, 4'h0);
    do_req(1'b0, 32'h0000_0008, '0, 4'h0);

    // All clusters up, withdrawn while they are still ramping
    do_req(1'b1, 32'h0000_0000, 32'h1F, 4'hF);
    idle(1);
    do_req(1'b1, 32'h0000_0000, 32'h0, 4'hF);
    idle(14);

    // Decode errors, and strobed scratch write
    do_req(1'b0, 32'h0000_0010, '0, 4'h0);
    do_req(1'b0, 32'h0000_0002, '0, 4'h0);
    do_req(1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 4'hF);
    do_req(1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 4'b0101);
    do_req(1'b0, 32'h0000_000C, '0, 4'h0);
    idle(1);

    // Reset while cluster 1 ramps and a read is waiting to be sampled
    do_req(1'b1, 32'h0000_0000, 32'h2, 4'hF);
    idle(1);
    reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 32'h0000_0004; reg_wstrb = '0;
    step(s);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("async_rst");
    reg_valid = 1'b0;
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(6);

    for (int n = 0; n < 250; n++) begin
      do_req(1'($urandom), rand_addr(), $urandom, 4'($urandom));
      idle($urandom_range(0, 12));
    end
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
